fc_hwpe_tcdm_funnel: RTL



---
 rtl/fc_hwpe_pkg.sv | 30 +++
 rtl/fc_tcdm_id_fifo.sv | 64 ++++++
 rtl/fc_hwpe_tcdm_funnel.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fc_hwpe_pkg.sv
// Shared types for the FC HWPE TCDM funnel: request/response records and the
// upstream port-index type used to tag outstanding transactions.
package fc_hwpe_pkg;

    localparam int unsigned FC_N_PORTS        = 32'd4;
    localparam int unsigned FC_ADDR_WIDTH     = 32'd32;
    localparam int unsigned FC_DATA_WIDTH     = 32'd32;
    localparam int unsigned FC_BE_WIDTH       = FC_DATA_WIDTH / 32'd8;
    localparam int unsigned FC_PORT_IDX_WIDTH = $clog2(FC_N_PORTS);

    typedef logic [FC_PORT_IDX_WIDTH-1:0] port_idx_t;

    typedef struct packed {
        logic [FC_ADDR_WIDTH-1:0] add;
        logic                     wen;
        logic [FC_BE_WIDTH-1:0]   be;
        logic [FC_DATA_WIDTH-1:0] wdata;
    } tcdm_req_t;

    typedef struct packed {
        logic [FC_DATA_WIDTH-1:0] rdata;
        logic                     valid;
    } tcdm_rsp_t;

    // Index width that stays legal for any port count, including 1.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/fc_tcdm_id_fifo.sv
// Synchronous FIFO of upstream port indices, one entry per granted request,
// popped in order as responses come back.
module fc_tcdm_id_fifo
    import fc_hwpe_pkg::*;
#(
    parameter int unsigned DEPTH = 32'd4,
    parameter int unsigned IDX_W = 32'd2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [IDX_W-1:0]         push_idx_i,
    input  logic                     pop_i,
    output logic [IDX_W-1:0]         head_idx_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [IDX_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o     = (r_count == (PTR_W+1)'(DEPTH));
    assign empty_o    = (r_count == '0);
    assign count_o    = r_count;
    assign head_idx_o = r_mem[r_rd_ptr];
    assign w_push     = push_i & ~full_o;
    assign w_pop      = pop_i & ~empty_o;

    // Storage array; contents are don't-care while the slot is not occupied.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_idx_i;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fc_hwpe_tcdm_funnel.sv
// Merges N upstream TCDM request ports onto one downstream port with a
// round-robin arbiter, and routes in-order responses back by tagged port index.
module fc_hwpe_tcdm_funnel
    import fc_hwpe_pkg::*;
#(
    parameter int unsigned N_PORTS         = FC_N_PORTS,
    parameter int unsigned ADDR_WIDTH      = FC_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH      = FC_DATA_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = 32'd4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [N_PORTS-1:0]                 in_req_i,
    output logic [N_PORTS-1:0]                 in_gnt_o,
    input  logic [N_PORTS*ADDR_WIDTH-1:0]      in_add_i,
    input  logic [N_PORTS-1:0]                 in_wen_i,
    input  logic [N_PORTS*(DATA_WIDTH/8)-1:0]  in_be_i,
    input  logic [N_PORTS*DATA_WIDTH-1:0]      in_wdata_i,
    output logic [N_PORTS*DATA_WIDTH-1:0]      in_r_rdata_o,
    output logic [N_PORTS-1:0]                 in_r_valid_o,
    output logic                               out_req_o,
    input  logic                               out_gnt_i,
    output logic [ADDR_WIDTH-1:0]              out_add_o,
    output logic                               out_wen_o,
    output logic [DATA_WIDTH/8-1:0]            out_be_o,
    output logic [DATA_WIDTH-1:0]              out_wdata_o,
    input  logic [DATA_WIDTH-1:0]              out_r_rdata_i,
    input  logic                               out_r_valid_i,
    output logic                               busy_o,
    output logic                               err_o
);

    localparam int unsigned IDX_W = idx_width(N_PORTS);
    localparam int unsigned BE_W  = DATA_WIDTH / 32'd8;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 32'd1;

    logic [IDX_W-1:0] r_rr;
    logic             r_err;
    logic [IDX_W-1:0] w_winner;
    logic [IDX_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_hs;
    logic             w_pop;

    // First asserted request scanning upward from the round-robin pointer, with wrap.
    always_comb begin : p_arb
        int unsigned k;
        logic        found;
        w_winner = '0;
        found    = 1'b0;
        k        = 32'd0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            k = (32'(r_rr) + i) % N_PORTS;
            if (!found && in_req_i[k]) begin
                found    = 1'b1;
                w_winner = IDX_W'(k);
            end else begin
                found    = found;
            end
        end
    end

    // fifo_full comes from the registered count, so no path from out_r_valid_i to out_req_o.
    assign out_req_o = (|in_req_i) & ~w_full;
    assign w_hs      = out_req_o & out_gnt_i;
    assign w_pop     = out_r_valid_i & ~w_empty;

    // Request field mux and one-hot grant/response steering.
    always_comb begin
        out_add_o    = in_add_i[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
        out_wen_o    = in_wen_i[w_winner];
        out_be_o     = in_be_i[int'(w_winner)*BE_W +: BE_W];
        out_wdata_o  = in_wdata_i[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];
        in_gnt_o     = '0;
        in_r_valid_o = '0;
        if (w_hs) begin
            in_gnt_o[w_winner] = 1'b1;
        end else begin
            in_gnt_o = '0;
        end
        if (w_pop) begin
            in_r_valid_o[w_head] = 1'b1;
        end else begin
            in_r_valid_o = '0;
        end
    end

    assign in_r_rdata_o = {N_PORTS{out_r_rdata_i}};
    assign busy_o       = (w_count != '0);
    assign err_o        = r_err;

    // Round-robin pointer advance and sticky error on a response with nothing outstanding.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr  <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_hs) begin
                r_rr <= (w_winner == IDX_W'(N_PORTS - 32'd1)) ? '0 : w_winner + 1'b1;
            end
            r_err <= r_err | (out_r_valid_i & w_empty);
        end
    end

    fc_tcdm_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .IDX_W (IDX_W)
    ) u_id_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (w_hs),
        .push_idx_i (w_winner),
        .pop_i      (w_pop),
        .head_idx_o (w_head),
        .full_o     (w_full),
        .empty_o    (w_empty),
        .count_o    (w_count)
    );

endmodule
